// File: rtl/max7219_pkg.sv
// Shared constants and state types for the MAX7219 command sequencer.
package max7219_pkg;

   localparam logic [7:0] REG_DIGIT0    = 8'h01;
   localparam logic [7:0] REG_DECODE    = 8'h09;
   localparam logic [7:0] REG_INTENSITY = 8'h0A;
   localparam logic [7:0] REG_SCANLIM   = 8'h0B;
   localparam logic [7:0] REG_SHUTDN    = 8'h0C;
   localparam logic [7:0] REG_TEST      = 8'h0F;

   typedef enum logic [2:0] {
      WAIT_PWR,
      INIT,
      CLEAR,
      IDLE,
      INT,
      ROWS
   } top_state_t;

   typedef enum logic [1:0] {
      H_IDLE,
      H_REQ,
      H_WAIT_LOW
   } hs_state_t;

endpackage

// File: rtl/max7219_if.sv
// Word handshake between the sequencer and the MAX7219 SPI serializer.
interface max7219_if;
   logic       str;
   logic [7:0] IRreg;
   logic [7:0] data;
   logic       busy;

   modport master (output str, output IRreg, output data, input busy);
   modport slave  (input str, input IRreg, input data, output busy);
endinterface

// File: rtl/max7219_word_hs.sv
// One register/data word per str/busy handshake; busy is synchronized here.
//   state      | meaning
//   H_IDLE     | str low, waiting for go to latch the next word
//   H_REQ      | str high, word held, waiting for busy_s=1
//   H_WAIT_LOW | str low, waiting for busy_s=0 (word accepted)
module max7219_word_hs
   import max7219_pkg::*;
(
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       go_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] dat_i,
   output logic       done_o,
   max7219_if.master  ser
);

   hs_state_t  state_q, state_d;
   logic       busy_m_q, busy_s_q;
   logic       str_q, str_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] dat_q, dat_d;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q  <= H_IDLE;
         busy_m_q <= 1'b0;
         busy_s_q <= 1'b0;
         str_q    <= 1'b0;
         ir_q     <= 8'h00;
         dat_q    <= 8'h00;
      end else begin
         state_q  <= state_d;
         busy_m_q <= ser.busy;
         busy_s_q <= busy_m_q;
         str_q    <= str_d;
         ir_q     <= ir_d;
         dat_q    <= dat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      str_d   = str_q;
      ir_d    = ir_q;
      dat_d   = dat_q;
      done_o  = 1'b0;
      unique case (state_q)
         H_IDLE: begin
            if (go_i) begin
               ir_d    = addr_i;
               dat_d   = dat_i;
               str_d   = 1'b1;
               state_d = H_REQ;
            end
         end
         H_REQ: begin
            if (busy_s_q) begin
               str_d   = 1'b0;
               state_d = H_WAIT_LOW;
            end
         end
         H_WAIT_LOW: begin
            if (!busy_s_q) begin
               done_o  = 1'b1;
               state_d = H_IDLE;
            end
         end
         default: state_d = H_IDLE;
      endcase
   end

   assign ser.str   = str_q;
   assign ser.IRreg = ir_q;
   assign ser.data  = dat_q;

endmodule

// File: rtl/max7219_ctrl.sv
// MAX7219 command sequencer: power-up delay, init, clear, then frame/intensity passes.
//   state    | meaning
//   WAIT_PWR | power-up delay down-counter running
//   INIT     | sending the 5 configuration words
//   CLEAR    | blanking digit rows 1..8
//   IDLE     | picking the next pass (intensity before frame)
//   INT      | sending one intensity word
//   ROWS     | sending the 8 shadow rows
module max7219_ctrl
   import max7219_pkg::*;
#(
   parameter int         STARTUP_CYCLES = 1000,
   parameter logic [2:0] SCAN_LIMIT     = 3'd7
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic [63:0] frame,
   input  logic        frame_load,
   input  logic [3:0]  intensity,
   input  logic        int_load,
   output logic        init_done,
   output logic        frame_done,
   max7219_if.master   ser
);

   localparam int CW = $clog2(STARTUP_CYCLES + 1);

   top_state_t  state_q, state_d;
   logic [CW-1:0] tmr_q, tmr_d;
   logic [2:0]  wcnt_q, wcnt_d;
   logic [63:0] stage_q, stage_d;
   logic [63:0] shadow_q, shadow_d;
   logic        frame_pend_q, frame_pend_d;
   logic        int_pend_q, int_pend_d;
   logic        init_done_q, init_done_d;
   logic        frame_done_q, frame_done_d;
   logic        go;
   logic        hs_done;
   logic [7:0]  w_addr, w_data;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q      <= WAIT_PWR;
         tmr_q        <= CW'(STARTUP_CYCLES - 1);
         wcnt_q       <= 3'd0;
         stage_q      <= 64'h0;
         shadow_q     <= 64'h0;
         frame_pend_q <= 1'b0;
         int_pend_q   <= 1'b0;
         init_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         wcnt_q       <= wcnt_d;
         stage_q      <= stage_d;
         shadow_q     <= shadow_d;
         frame_pend_q <= frame_pend_d;
         int_pend_q   <= int_pend_d;
         init_done_q  <= init_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      tmr_d        = tmr_q;
      wcnt_d       = wcnt_q;
      stage_d      = stage_q;
      shadow_d     = shadow_q;
      frame_pend_d = frame_pend_q;
      int_pend_d   = int_pend_q;
      init_done_d  = init_done_q;
      frame_done_d = 1'b0;
      go           = 1'b0;
      w_addr       = 8'h00;
      w_data       = 8'h00;
      unique case (state_q)
         WAIT_PWR: begin
            if (tmr_q == '0) state_d = INIT;
            else             tmr_d   = tmr_q - CW'(1);
         end
         INIT: begin
            go = 1'b1;
            case (wcnt_q)
               3'd0:    begin w_addr = REG_TEST;      w_data = 8'h00;              end
               3'd1:    begin w_addr = REG_DECODE;    w_data = 8'h00;              end
               3'd2:    begin w_addr = REG_INTENSITY; w_data = {4'h0, intensity};  end
               3'd3:    begin w_addr = REG_SCANLIM;   w_data = {5'b0, SCAN_LIMIT}; end
               default: begin w_addr = REG_SHUTDN;    w_data = 8'h01;              end
            endcase
            if (hs_done) begin
               if (wcnt_q == 3'd4) begin
                  wcnt_d  = 3'd0;
                  state_d = CLEAR;
               end else begin
                  wcnt_d = wcnt_q + 3'd1;
               end
            end
         end
         CLEAR: begin
            go     = 1'b1;
            w_addr = REG_DIGIT0 + {5'b0, wcnt_q};
            if (hs_done) begin
               wcnt_d = wcnt_q + 3'd1;
               if (wcnt_q == 3'd7) begin
                  state_d     = IDLE;
                  init_done_d = 1'b1;
               end
            end
         end
         IDLE: begin
            if (int_pend_q) begin
               state_d = INT;
            end else if (frame_pend_q) begin
               shadow_d     = stage_q;
               frame_pend_d = 1'b0;
               state_d      = ROWS;
            end
         end
         INT: begin
            go     = 1'b1;
            w_addr = REG_INTENSITY;
            w_data = {4'h0, intensity};
            if (hs_done) begin
               int_pend_d = 1'b0;
               state_d    = IDLE;
            end
         end
         ROWS: begin
            go     = 1'b1;
            w_addr = REG_DIGIT0 + {5'b0, wcnt_q};
            w_data = shadow_q[{wcnt_q, 3'b000} +: 8];
            if (hs_done) begin
               wcnt_d = wcnt_q + 3'd1;
               if (wcnt_q == 3'd7) begin
                  frame_done_d = 1'b1;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = WAIT_PWR;
      endcase
      // New requests win over the clear of a flag in the same cycle.
      if (frame_load) begin
         stage_d      = frame;
         frame_pend_d = 1'b1;
      end
      if (int_load) int_pend_d = 1'b1;
   end

   max7219_word_hs u_hs (
      .sys_clk (sys_clk),
      .rst     (rst),
      .go_i    (go),
      .addr_i  (w_addr),
      .dat_i   (w_data),
      .done_o  (hs_done),
      .ser     (ser)
   );

   assign init_done  = init_done_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max7219_ctrl.sv
// Directed bench with a behavioural serializer and an expected-word queue.
module tb_max7219_ctrl;

   localparam int STARTUP = 1000;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic [63:0] frame;
   logic        frame_load;
   logic [3:0]  intensity;
   logic        int_load;
   logic        init_done;
   logic        frame_done;

   max7219_if ser_if ();

   max7219_ctrl #(.STARTUP_CYCLES(STARTUP), .SCAN_LIMIT(3'd7)) dut (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .frame      (frame),
      .frame_load (frame_load),
      .intensity  (intensity),
      .int_load   (int_load),
      .init_done  (init_done),
      .frame_done (frame_done),
      .ser        (ser_if)
   );

   always #5 sys_clk = ~sys_clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] exp_q[$];
   typedef enum {S_IDLE, S_RUN, S_HIGH} sph_t;
   sph_t        ph = S_IDLE;
   int          cnt = 0;
   int          since_fall = 100;
   int          acc_cnt = 0;
   int          fd_cnt = 0;
   int          ser_delay = 20;
   int          ser_high = 5;
   logic        fd_prev = 1'b0;
   logic        id_prev = 1'b0;
   logic [15:0] cur_word = 16'h0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #2;
   endtask

   task automatic push_init();
      exp_q.push_back(16'h0F00);
      exp_q.push_back(16'h0900);
      exp_q.push_back({8'h0A, 4'h0, intensity});
      exp_q.push_back(16'h0B07);
      exp_q.push_back(16'h0C01);
      for (int k = 0; k < 8; k++) exp_q.push_back({8'(k + 1), 8'h00});
   endtask

   task automatic push_rows(input logic [63:0] f);
      for (int k = 0; k < 8; k++) exp_q.push_back({8'(k + 1), f[8*k +: 8]});
   endtask

   task automatic load_frame(input logic [63:0] f);
      frame      = f;
      frame_load = 1'b1;
      tick();
      frame_load = 1'b0;
   endtask

   task automatic release_and_time(input string nm);
      int k;
      rst = 1'b0;
      push_init();
      for (k = 1; k <= STARTUP + 50; k++) begin
         tick();
         if (ser_if.str) break;
      end
      chk(nm, 64'(k), 64'(STARTUP + 1));
   endtask

   task automatic wait_init(input string nm);
      for (int i = 0; i < 2000 && !init_done; i++) tick();
      chk(nm, 64'(init_done), 64'(1));
   endtask

   task automatic wait_fd(input int target, input int budget, input string nm);
      for (int i = 0; i < budget && fd_cnt < target; i++) tick();
      repeat (3) tick();
      chk(nm, 64'(fd_cnt), 64'(target));
      chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
   endtask

   task automatic wait_acc(input int n, input string nm);
      for (int i = 0; i < 2000 && acc_cnt < n; i++) tick();
      chk(nm, 64'(acc_cnt >= n), 64'(1));
   endtask

   // Serializer model and per-cycle checker, sampled mid-cycle.
   always @(negedge sys_clk) begin
      if (rst) begin
         ph          = S_IDLE;
         ser_if.busy = 1'b0;
         since_fall  = 100;
         acc_cnt     = 0;
         cnt         = 0;
         fd_prev     = 1'b0;
         id_prev     = 1'b0;
         exp_q.delete();
      end else begin
         if (since_fall < 100) since_fall++;
         if (frame_done) begin
            fd_cnt++;
            chk("frame_done_width", 64'(fd_prev), 64'(0));
            chk("frame_done_timing", 64'({cur_word[15:8], 8'(since_fall)}), 64'({8'h08, 8'd3}));
         end
         if (init_done && !id_prev) chk("init_done_after_0800", 64'(acc_cnt), 64'(13));
         if (id_prev) chk("init_done_sticky", 64'(init_done), 64'(1));
         fd_prev = frame_done;
         id_prev = init_done;
         case (ph)
            S_IDLE: begin
               if (ser_if.str) begin
                  chk("str_low_gap", 64'(since_fall >= 4), 64'(1));
                  cur_word = {ser_if.IRreg, ser_if.data};
                  if (exp_q.size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL unexpected_word: got %h required none", cur_word);
                  end else begin
                     chk("word", 64'(cur_word), 64'(exp_q.pop_front()));
                  end
                  cnt = 0;
                  ph  = S_RUN;
               end
            end
            S_RUN: begin
               chk("hold_before_busy", 64'({ser_if.str, ser_if.IRreg, ser_if.data}),
                   64'({1'b1, cur_word}));
               cnt++;
               if (cnt >= ser_delay) begin
                  ser_if.busy = 1'b1;
                  cnt = 0;
                  ph  = S_HIGH;
               end
            end
            S_HIGH: begin
               cnt++;
               if (cnt < 3)
                  chk("hold_during_sync", 64'({ser_if.str, ser_if.IRreg, ser_if.data}),
                      64'({1'b1, cur_word}));
               else
                  chk("str_fall", 64'(ser_if.str), 64'(0));
               if (cnt == ser_high) begin
                  ser_if.busy = 1'b0;
                  since_fall  = 0;
                  acc_cnt++;
               end
               if (cnt >= 3 && cnt >= ser_high) ph = S_IDLE;
            end
            default: ph = S_IDLE;
         endcase
      end
   end

   initial begin
      int base;
      rst         = 1'b1;
      frame       = 64'h0;
      frame_load  = 1'b0;
      intensity   = 4'h3;
      int_load    = 1'b0;
      ser_if.busy = 1'b0;
      repeat (3) tick();
      chk("rst_str",        64'(ser_if.str),   64'(0));
      chk("rst_irreg",      64'(ser_if.IRreg), 64'(0));
      chk("rst_data",       64'(ser_if.data),  64'(0));
      chk("rst_init_done",  64'(init_done),    64'(0));
      chk("rst_frame_done", 64'(frame_done),   64'(0));

      release_and_time("first_str_latency");
      wait_init("init_done_1");

      // Diagonal frame, expected words written out by hand.
      exp_q.push_back(16'h0101); exp_q.push_back(16'h0202);
      exp_q.push_back(16'h0304); exp_q.push_back(16'h0408);
      exp_q.push_back(16'h0510); exp_q.push_back(16'h0620);
      exp_q.push_back(16'h0740); exp_q.push_back(16'h0880);
      load_frame(64'h8040201008040201);
      wait_fd(1, 2000, "diag_pass");

      // Two loads during a pass collapse to one extra pass carrying the latest.
      base = acc_cnt;
      push_rows(64'h0123456789ABCDEF);
      load_frame(64'h0123456789ABCDEF);
      wait_acc(base + 2, "mid_pass_a");
      load_frame(64'hDEADBEEFCAFEF00D);
      wait_acc(base + 4, "mid_pass_b");
      push_rows(64'h55AA33CC0FF01234);
      load_frame(64'h55AA33CC0FF01234);
      wait_fd(3, 3000, "collapse_pass");
      repeat (200) tick();
      chk("no_extra_pass", 64'(fd_cnt), 64'(3));

      // Simultaneous loads: intensity word goes first.
      intensity  = 4'hF;
      frame      = 64'hF00F_1234_8001_7E42;
      exp_q.push_back(16'h0A0F);
      push_rows(64'hF00F_1234_8001_7E42);
      frame_load = 1'b1;
      int_load   = 1'b1;
      tick();
      frame_load = 1'b0;
      int_load   = 1'b0;
      wait_fd(4, 3000, "int_then_rows");

      // Slow serializer with a one-cycle busy pulse; intensity moves while str waits.
      ser_delay = 60;
      ser_high  = 1;
      intensity = 4'h5;
      exp_q.push_back(16'h0A05);
      int_load  = 1'b1;
      tick();
      int_load  = 1'b0;
      for (int i = 0; i < 50 && !ser_if.str; i++) tick();
      chk("slow_str_seen", 64'(ser_if.str), 64'(1));
      tick();
      intensity = 4'h9;
      wait_acc(acc_cnt + 1, "slow_int_accepted");
      push_rows(64'h0011_2233_4455_6677);
      load_frame(64'h0011_2233_4455_6677);
      wait_fd(5, 3000, "slow_pass");

      // Reset in the middle of a row pass.
      ser_delay = 20;
      ser_high  = 5;
      push_rows(64'hA5A5_5A5A_C3C3_3C3C);
      load_frame(64'hA5A5_5A5A_C3C3_3C3C);
      for (int i = 0; i < 1000 && !(ser_if.str && ser_if.IRreg == 8'h03); i++) tick();
      chk("mid_rows_str", 64'({ser_if.str, ser_if.IRreg}), 64'({1'b1, 8'h03}));
      rst = 1'b1;
      tick();
      chk("midrst_str",       64'(ser_if.str),   64'(0));
      chk("midrst_init_done", 64'(init_done),    64'(0));
      chk("midrst_irreg",     64'(ser_if.IRreg), 64'(0));
      tick();
      release_and_time("replay_latency");
      // Frame loaded before init completes is shown right after init.
      push_rows(64'h1818_2424_4242_8181);
      load_frame(64'h1818_2424_4242_8181);
      wait_init("init_done_2");
      wait_fd(6, 3000, "early_load_pass");
      repeat (200) tick();
      chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
